// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one start/done divider among NUM_REQ requesters.
// Optional feature: define DIV_ARB_ZERO_BYPASS_EN to answer zero-divisor jobs without the divider.
module divider_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int DIVIDEND_WIDTH = 32,
    parameter  int DIVISOR_WIDTH  = 32,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DIVIDEND_WIDTH-1:0]           rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]            rsp_remainder,
    output logic                                rsp_overflow,
    output logic                                div_start,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]            div_remainder,
    input  logic                                div_overflow,
    input  logic                                div_done,
    output logic                                busy,
    output logic [ID_W-1:0]                     grant_id
);

`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state;
    logic [ID_W-1:0]            r_ptr;
    logic [ID_W-1:0]            r_grant_id;
    logic                       r_bypass;
    logic                       r_busy;
    logic [NUM_REQ-1:0]         r_req_ready;
    logic [NUM_REQ-1:0]         r_rsp_valid;
    logic [DIVIDEND_WIDTH-1:0]  r_rsp_quotient;
    logic [DIVISOR_WIDTH-1:0]   r_rsp_remainder;
    logic                       r_rsp_overflow;
    logic                       r_div_start;
    logic [DIVIDEND_WIDTH-1:0]  r_div_dividend;
    logic [DIVISOR_WIDTH-1:0]   r_div_divisor;

    logic                       w_any;
    logic [ID_W-1:0]            w_idx;
    logic [ID_W-1:0]            w_gnt;
    logic [DIVIDEND_WIDTH-1:0]  w_dividend;
    logic [DIVISOR_WIDTH-1:0]   w_divisor;

    // Search upward from the slot after the last owner, wrapping, so the last owner goes last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_any = 1'b0;
        w_idx = '0;
        w_gnt = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
        w_dividend = req_dividend[int'(w_gnt)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        w_divisor  = req_divisor[int'(w_gnt)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= ID_W'(NUM_REQ - 1);
            r_grant_id      <= '0;
            r_bypass        <= 1'b0;
            r_busy          <= 1'b0;
            r_req_ready     <= '0;
            r_rsp_valid     <= '0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_overflow  <= 1'b0;
            r_div_start     <= 1'b0;
            r_div_dividend  <= '0;
            r_div_divisor   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_req_ready    <= NUM_REQ'(1) << w_gnt;
                        r_div_dividend <= w_dividend;
                        r_div_divisor  <= w_divisor;
                        r_ptr          <= w_gnt;
                        r_grant_id     <= w_gnt;
                        r_bypass       <= ZERO_BYPASS && (w_divisor == '0);
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A bypassed job answers here so rsp_valid lands one cycle after req_ready.
                    if (r_bypass) begin
                        r_rsp_valid     <= NUM_REQ'(1) << r_grant_id;
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= DIVISOR_WIDTH'($signed(r_div_dividend));
                        r_rsp_overflow  <= 1'b1;
                        r_state         <= S_RESP;
                    end else begin
                        r_div_start <= 1'b1;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_done) begin
                        r_rsp_valid     <= NUM_REQ'(1) << r_grant_id;
                        r_rsp_quotient  <= div_quotient;
                        r_rsp_remainder <= div_remainder;
                        r_rsp_overflow  <= div_overflow;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_overflow  = r_rsp_overflow;
    assign div_start     = r_div_start;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign busy          = r_busy;
    assign grant_id      = r_grant_id;

endmodule
